wb_sram_target: RTL



---
 rtl/wb_sram_target_if.sv | 31 +++
 rtl/wb_sram_target.sv | 119 +++++++++++
 2 files changed

// File: rtl/wb_sram_target_if.sv
// wb_sram_target_if.sv
// Wishbone bus bundle between an interconnect master port and a target.
//   master modport: drives ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE;
//                   receives DAT_R, ACK, ERR
//   slave modport : the mirror image of master
interface wb_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [2:0]                 CTI;
  logic [1:0]                 BTE;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       CYC;
  logic                       STB;
  logic                       WE;
  logic [WB_DATA_WIDTH-1:0]   DAT_R;
  logic                       ACK;
  logic                       ERR;

  modport master (
    output ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_target.sv
// wb_sram_target.sv
// Wishbone target backed by a single-port, byte-writable on-chip SRAM.
// Handles classic cycles and registered-feedback incrementing bursts
// (linear, wrap4/8/16), and answers ERR for beats outside its window.
//   clk  : sole clock, rising edge
//   rstn : synchronous active-low reset
//   s    : Wishbone slave side (ADR/CTI/BTE/DAT_W/SEL/CYC/STB/WE in,
//          DAT_R/ACK/ERR out, all outputs registered)
module wb_sram_target #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
  parameter int                       MEM_WORDS     = 1024
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);

  localparam int SEL_W  = WB_DATA_WIDTH / 8;
  localparam int B      = $clog2(SEL_W);
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [WB_ADDR_WIDTH-1:0] WORDS_LIM = WB_ADDR_WIDTH'(MEM_WORDS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state;
  // baddr holds the word index of the beat currently being answered
  logic [WB_ADDR_WIDTH-1:0] baddr;
  logic [WB_ADDR_WIDTH-1:0] req_idx;
  logic [WB_ADDR_WIDTH-1:0] next_idx;
  logic [WB_ADDR_WIDTH-1:0] wrap_mask;
  logic                     req_in;
  logic                     next_in;
  logic                     beat_done;
  logic                     commit;

  logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Subtraction wraps modulo 2^WB_ADDR_WIDTH, so addresses below the
  // base land on huge indices and fall out of range naturally.
  always_comb begin
    req_idx = (s.ADR - ADDR_BASE) >> B;
    req_in  = req_idx < WORDS_LIM;

    case (s.BTE)
      2'b01:   wrap_mask = WB_ADDR_WIDTH'(3);
      2'b10:   wrap_mask = WB_ADDR_WIDTH'(7);
      2'b11:   wrap_mask = WB_ADDR_WIDTH'(15);
      default: wrap_mask = '0;
    endcase

    // Wrapped bursts only step the low bits; the block base stays put.
    if (s.BTE == 2'b00) begin
      next_idx = baddr + 1'b1;
    end else begin
      next_idx = (baddr & ~wrap_mask) | ((baddr + 1'b1) & wrap_mask);
    end
    next_in = next_idx < WORDS_LIM;
  end

  // In ACTIVE a response is always up, so a beat finishes as soon as
  // the master still holds CYC and STB at the edge.
  assign beat_done = (state == ACTIVE) && (s.ACK || s.ERR) && s.CYC && s.STB;
  assign commit    = beat_done && s.ACK && s.WE;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      baddr   <= '0;
      s.ACK   <= 1'b0;
      s.ERR   <= 1'b0;
      s.DAT_R <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.CYC && s.STB) begin
            state <= ACTIVE;
            baddr <= req_idx;
            s.ACK <= req_in;
            s.ERR <= !req_in;
            if (req_in) begin
              s.DAT_R <= mem[req_idx[MEM_AW-1:0]];
            end
          end
        end
        ACTIVE: begin
          // The next beat always targets a different word than the one
          // being written now, so reading the array here is never stale.
          if (beat_done && s.ACK && (s.CTI == 3'b010)) begin
            baddr <= next_idx;
            s.ACK <= next_in;
            s.ERR <= !next_in;
            if (next_in) begin
              s.DAT_R <= mem[next_idx[MEM_AW-1:0]];
            end
          end else begin
            state <= IDLE;
            s.ACK <= 1'b0;
            s.ERR <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset edge simply suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && commit) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (s.SEL[i]) begin
          mem[baddr[MEM_AW-1:0]][i*8 +: 8] <= s.DAT_W[i*8 +: 8];
        end
      end
    end
  end

endmodule
